// File: rtl/fetch_unit.sv
// Instruction fetch front end: PC, credit-limited imem requests, instruction FIFO.
// Optional FETCH_PERF_EN adds perf_fetched / perf_bubbles counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetched,
  output logic [31:0] perf_bubbles
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] word;
    logic [31:0] pc;
  } entry_t;

  logic [31:0]   pc;
  logic [CW-1:0] outstanding;
  logic [CW-1:0] discard;

  entry_t        fifo_q [FIFO_DEPTH];
  logic [CW-1:0] f_wr;
  logic [CW-1:0] f_rd;
  logic [CW-1:0] f_cnt;

  logic [31:0]   tq [FIFO_DEPTH];
  logic [CW-1:0] t_wr;
  logic [CW-1:0] t_rd;

  logic [CW:0]   occ;
  logic          credit_ok;
  logic          accept;
  logic          rsp_keep;
  logic          rsp_drop;
  logic          push;
  logic          pop;
  logic [CW-1:0] out_dec;
  logic [31:0]   redir_tgt;

  assign f_cnt     = f_wr - f_rd;
  assign occ       = (CW+1)'(outstanding) + (CW+1)'(f_cnt);
  assign credit_ok = occ < (CW+1)'(FIFO_DEPTH);

  // Gate with rst so requests are quiet while reset is held
  assign imem_req_valid = rst && credit_ok && !redirect_valid;
  assign imem_req_addr  = pc;

  assign accept   = imem_req_valid && imem_req_ready;
  assign rsp_keep = imem_rsp_valid && (discard == '0);
  assign rsp_drop = imem_rsp_valid && (discard != '0);
  assign push     = rsp_keep && !redirect_valid;

  assign inst_valid = (f_cnt != '0) && !redirect_valid;
  assign inst       = fifo_q[f_rd[AW-1:0]].word;
  assign inst_pc    = fifo_q[f_rd[AW-1:0]].pc;
  assign pop        = inst_valid && !stall;

  assign out_dec   = outstanding - CW'(imem_rsp_valid);
  assign redir_tgt = redirect_pc & 32'hFFFF_FFFC;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc          <= RESET_PC;
      outstanding <= '0;
      discard     <= '0;
      t_wr        <= '0;
      t_rd        <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        tq[i] <= '0;
      end
    end else if (redirect_valid) begin
      // Everything still in flight belongs to the old path
      pc          <= redir_tgt;
      outstanding <= out_dec;
      discard     <= out_dec;
      t_wr        <= '0;
      t_rd        <= '0;
    end else begin
      outstanding <= out_dec + CW'(accept);
      if (rsp_drop) discard <= discard - 1'b1;
      if (accept) begin
        pc              <= pc + 32'd4;
        tq[t_wr[AW-1:0]] <= pc;
        t_wr            <= t_wr + 1'b1;
      end
      if (rsp_keep) t_rd <= t_rd + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f_wr <= '0;
      f_rd <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        fifo_q[i] <= '0;
      end
    end else if (redirect_valid) begin
      f_wr <= '0;
      f_rd <= '0;
    end else begin
      if (push) begin
        fifo_q[f_wr[AW-1:0]] <= '{word: imem_rsp_data,
                                  pc:   tq[t_rd[AW-1:0]]};
        f_wr <= f_wr + 1'b1;
      end
      if (pop) f_rd <= f_rd + 1'b1;
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_fetched <= '0;
      perf_bubbles <= '0;
    end else begin
      if (pop) perf_fetched <= perf_fetched + 32'd1;
      if (!inst_valid && !stall) perf_bubbles <= perf_bubbles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit against a queue-based model of
// the memory path and delivered instruction stream.
module tb_fetch_unit;

  localparam logic [31:0] RPC = 32'h0000_0100;
  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .inst_valid     (inst_valid),
    .inst           (inst),
    .inst_pc        (inst_pc)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    bit          stale;
    int          cyc;
  } mreq_t;

  mreq_t       memq [$];
  logic [31:0] mfifo [$];
  logic [31:0] exp_addr;
  int          cyc;
  int          total;
  int          bad;
  bit          last_iv;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5EED_1234;
  endfunction

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic cycle(input bit rdy, input bit rsp_en, input bit stl,
                       input bit rdr, input logic [31:0] rpc);
    bit    ev_rsp, m_rv, m_iv, acc, pp;
    mreq_t h;
    ev_rsp = rsp_en && memq.size() > 0 && memq[0].cyc < cyc;
    imem_req_ready = rdy;
    stall          = stl;
    redirect_valid = rdr;
    redirect_pc    = rpc;
    imem_rsp_valid = ev_rsp;
    imem_rsp_data  = ev_rsp ? word_of(memq[0].addr) : $urandom;
    #1;
    m_rv = !rdr && (memq.size() + mfifo.size() < DEPTH);
    m_iv = !rdr && mfifo.size() > 0;
    last_iv = inst_valid;
    check("req_valid", 32'(imem_req_valid), 32'(m_rv));
    if (m_rv) check("req_addr", imem_req_addr, exp_addr);
    check("inst_valid", 32'(inst_valid), 32'(m_iv));
    if (m_iv) begin
      check("inst_pc", inst_pc, mfifo[0]);
      check("inst", inst, word_of(mfifo[0]));
    end
    acc = m_rv && rdy;
    pp  = m_iv && !stl;
    @(posedge clk);
    if (rdr) begin
      mfifo.delete();
      if (ev_rsp) void'(memq.pop_front());
      foreach (memq[i]) memq[i].stale = 1'b1;
      exp_addr = rpc & 32'hFFFF_FFFC;
    end else begin
      if (pp) void'(mfifo.pop_front());
      if (ev_rsp) begin
        h = memq.pop_front();
        if (!h.stale) mfifo.push_back(h.addr);
      end
      if (acc) begin
        memq.push_back('{addr: exp_addr, stale: 1'b0, cyc: cyc});
        exp_addr += 32'd4;
      end
    end
    cyc++;
    #1;
  endtask

  task automatic idle_inputs();
    imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    stall          = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle_inputs();
    #1;
    check("rst_req_valid", 32'(imem_req_valid), 32'h0);
    check("rst_inst_valid", 32'(inst_valid), 32'h0);
    check("rst_inst", inst, 32'h0);
    check("rst_inst_pc", inst_pc, 32'h0);
    memq.delete();
    mfifo.delete();
    exp_addr = RPC;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  initial begin
    int first;
    total = 0;
    bad   = 0;
    cyc   = 0;
    rst   = 1'b0;
    idle_inputs();
    exp_addr = RPC;
    @(posedge clk);
    #1;
    do_reset();

    first = 0;
    for (int k = 1; k <= 20; k++) begin
      cycle(1, 1, 0, 0, '0);
      if (first == 0 && last_iv) first = k;
    end
    check("first_valid_cyc", 32'(first), 32'd3);

    repeat (6) cycle(1, 1, 1, 0, '0);
    repeat (10) cycle(1, 1, 0, 0, '0);

    repeat (2) cycle(1, 0, 1, 0, '0);
    cycle(1, 0, 0, 1, 32'h0000_0203);
    check("redir_addr", imem_req_addr, 32'h0000_0200);
    repeat (12) cycle(1, 1, 0, 0, '0);

    repeat (3) cycle(1, 0, 0, 0, '0);
    cycle(1, 1, 0, 1, 32'h0000_0480);
    repeat (12) cycle(1, 1, 0, 0, '0);

    cycle(1, 1, 0, 1, 32'h0000_0600);
    cycle(1, 1, 0, 1, 32'h0000_0700);
    repeat (8) cycle(1, 1, 0, 0, '0);

    repeat (4) cycle(0, 1, 0, 0, '0);
    repeat (6) cycle(1, 1, 0, 0, '0);

    repeat (4) cycle(1, 1, 1, 0, '0);
    cycle(1, 0, 1, 0, '0);
    do_reset();
    repeat (10) cycle(1, 1, 0, 0, '0);

    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        do_reset();
      end else begin
        cycle($urandom_range(0, 3) != 0,
              $urandom_range(0, 1) == 1,
              $urandom_range(0, 2) == 0,
              $urandom_range(0, 15) == 0,
              $urandom);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
